// File: rtl/stack_mem_ctrl_pkg.sv
// Shared definitions for the RAM-resident stack calculator: opcodes,
// FSM encoding, default stack bounds and the ADD/SUB datapath.
package stack_mem_ctrl_pkg;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_TOP  = 3'b100;
    localparam logic [2:0] OP_INC  = 3'b101;
    localparam logic [2:0] OP_DEC  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    localparam logic [6:0] DEF_STACK_BASE  = 7'h7F;
    localparam logic [6:0] DEF_STACK_LIMIT = 7'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_WR,
        S_POP,
        S_RD_A,
        S_RD_B,
        S_ALU_WR,
        S_MOVE,
        S_REFRESH
    } state_t;

    // b is the deeper operand, a the top of stack; carry/borrow drop off the top.
    function automatic logic [7:0] alu_result(input logic sub, input logic [7:0] b,
                                              input logic [7:0] a);
        return sub ? b - a : b + a;
    endfunction

endpackage

// File: rtl/stack_mem_ctrl.sv
// Stack calculator that drives the 128x8 negedge RAM bus; the stack lives in RAM
// and grows downward from STACK_BASE, with SPR pointing at the next free slot.
module stack_mem_ctrl
    import stack_mem_ctrl_pkg::*;
#(
    parameter logic [6:0] STACK_BASE  = DEF_STACK_BASE,
    parameter logic [6:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] op,
    input  logic       go,
    input  logic [7:0] swtchs,
    input  logic [7:0] mem_rdata,
    output logic       cs,
    output logic       we,
    output logic [6:0] addr,
    output logic [7:0] mem_wdata,
    output logic [7:0] leds,
    output logic [7:0] dvr,
    output logic       busy,
    output logic       err
);

    state_t     state, state_nxt;
    logic [6:0] spr, dar, spr_nxt, dar_nxt;
    logic [7:0] dvr_nxt, a_reg, b_reg, wdata_nxt;
    logic [2:0] op_q, op_nxt;
    logic       err_nxt, cs_nxt, we_nxt;
    logic [6:0] addr_nxt;
    logic [6:0] spr_p1, spr_p2, depth;
    logic       empty, full, go_err;

    assign spr_p1 = spr + 7'd1;
    assign spr_p2 = spr + 7'd2;
    assign depth  = STACK_BASE - spr;
    assign empty  = (spr == STACK_BASE);
    assign full   = (spr == STACK_LIMIT);
    assign busy   = (state != S_IDLE);
    assign leds   = {empty, dar};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        go_err = 1'b0;
        case (op)
            OP_PUSH:        go_err = full;
            OP_POP, OP_TOP: go_err = empty;
            OP_ADD, OP_SUB: go_err = (depth < 7'd2);
            default:        go_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go && !go_err) begin
                    case (op)
                        OP_PUSH:                state_nxt = S_PUSH_WR;
                        OP_POP:                 state_nxt = S_POP;
                        OP_ADD, OP_SUB:         state_nxt = S_RD_A;
                        OP_TOP, OP_INC, OP_DEC: state_nxt = S_MOVE;
                        default:                state_nxt = S_IDLE;
                    endcase
                end
            end
            S_PUSH_WR: state_nxt = S_IDLE;
            S_POP:     state_nxt = (spr_p1 == STACK_BASE) ? S_IDLE : S_REFRESH;
            S_RD_A:    state_nxt = S_RD_B;
            S_RD_B:    state_nxt = S_ALU_WR;
            S_ALU_WR:  state_nxt = S_IDLE;
            S_MOVE:    state_nxt = S_REFRESH;
            S_REFRESH: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Pointer and display updates take effect at the end of the state that owns them.
    always_comb begin
        spr_nxt = spr;
        dar_nxt = dar;
        dvr_nxt = dvr;
        err_nxt = err;
        op_nxt  = op_q;
        case (state)
            S_IDLE: begin
                if (go) begin
                    err_nxt = go_err;
                    op_nxt  = op;
                end
            end
            S_PUSH_WR: begin
                spr_nxt = spr - 7'd1;
                dar_nxt = spr;
                dvr_nxt = mem_wdata;
            end
            S_POP: begin
                spr_nxt = spr_p1;
                if (spr_p1 == STACK_BASE) begin
                    dar_nxt = STACK_BASE;
                    dvr_nxt = 8'h00;
                end else begin
                    dar_nxt = spr_p2;
                end
            end
            S_ALU_WR: begin
                spr_nxt = spr_p1;
                dar_nxt = spr_p2;
                dvr_nxt = alu_result(op_q == OP_SUB, b_reg, a_reg);
            end
            S_MOVE: begin
                case (op_q)
                    OP_TOP:  dar_nxt = spr_p1;
                    OP_INC:  dar_nxt = dar + 7'd1;
                    OP_DEC:  dar_nxt = dar - 7'd1;
                    default: dar_nxt = dar;
                endcase
            end
            S_REFRESH: dvr_nxt = mem_rdata;
            default: ;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        cs_nxt    = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = addr;
        wdata_nxt = mem_wdata;
        case (state_nxt)
            S_PUSH_WR: begin
                cs_nxt    = 1'b1;
                we_nxt    = 1'b1;
                addr_nxt  = spr;
                wdata_nxt = swtchs;
            end
            S_RD_A: begin
                cs_nxt   = 1'b1;
                addr_nxt = spr_p1;
            end
            S_RD_B: begin
                cs_nxt   = 1'b1;
                addr_nxt = spr_p2;
            end
            S_ALU_WR: begin
                cs_nxt    = 1'b1;
                we_nxt    = 1'b1;
                addr_nxt  = spr_p2;
                wdata_nxt = alu_result(op_q == OP_SUB, mem_rdata, a_reg);
            end
            S_REFRESH: begin
                cs_nxt   = 1'b1;
                addr_nxt = dar_nxt;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr       <= STACK_BASE;
            dar       <= STACK_BASE;
            dvr       <= 8'h00;
            err       <= 1'b0;
            op_q      <= OP_NOP;
            a_reg     <= 8'h00;
            b_reg     <= 8'h00;
            cs        <= 1'b0;
            we        <= 1'b0;
            addr      <= 7'h00;
            mem_wdata <= 8'h00;
        end else begin
            spr       <= spr_nxt;
            dar       <= dar_nxt;
            dvr       <= dvr_nxt;
            err       <= err_nxt;
            op_q      <= op_nxt;
            cs        <= cs_nxt;
            we        <= we_nxt;
            addr      <= addr_nxt;
            mem_wdata <= wdata_nxt;
            if (state == S_RD_A) a_reg <= mem_rdata;
            if (state == S_RD_B) b_reg <= mem_rdata;
        end
    end

endmodule
